dcache_lru_wb: RTL
==================

Name: dcache_lru_wb

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between the datapath and the memory controller.
- Next generation of the 2-way / 1-bit-MRU dcache frame. WAYS, WORDS per block and SETS are configurable.
- Replacement is true LRU using per-way age counters instead of a single MRU bit.
- Adds a halt-driven flush engine that writes back every dirty block before raising flushed.

Parameters:
- WAYS, 2, associativity; power of 2, ≥2.
- WORDS, 2, words per block; power of 2, ≥1.
- SETS, 8, number of sets; power of 2.
- WORD_W, 32, data word width.
- Derived: IDX_W = log2(SETS), BLK_W = log2(WORDS), TAG_W = 32-IDX_W-BLK_W-2, AGE_W = log2(WAYS).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- halt  in  1  datapath halt; starts flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- dmemaddr  in  32  byte address {tag, idx, blkoff, bytoff}.
- dmemstore  in  WORD_W  write data.
- dmemload  out  WORD_W  read data.
- dhit  out  1  request satisfied this cycle.
- flushed  out  1  flush complete; sticky until reset.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory word address, bytoff = 0.
- dstore  out  WORD_W  memory write data.
- dload  in  WORD_W  memory read data.
- dwait  in  1  memory busy; transfer completes on a cycle with dwait=0.

Behaviour:
- Reset, asynchronous on nRST low:
  - all valid and dirty bits 0; age[w] = w for every set.
  - FSM = IDLE; word counter = 0; flush pointers = 0.
  - dhit, flushed, dREN, dWEN = 0; daddr, dstore, dmemload = 0.
  - Reset mid-transfer abandons the transfer with no partial state retained.
- Lookup is combinational in IDLE. Hit = some way with v=1 and tag match (at most one). dmemREN and dmemWEN never assert together.
- Read hit: dhit=1 and dmemload = data[blkoff] in the same cycle (0-cycle latency).
- Write hit: dhit=1; on the clock edge write the word and set dirty=1.
- LRU update on every hit edge and on fill completion:
  - accessed way's age becomes 0.
  - every way with age < the old accessed age increments.
  - age WAYS-1 = least recently used.
- Victim selection: lowest-index invalid way; otherwise the way with age = WAYS-1.
- Miss, IDLE transitions:
  - victim valid and dirty → WB.
  - otherwise → FILL.
  - dhit=0 throughout the miss.
- WB:
  - dWEN=1, daddr = {victim tag, idx, cnt, 00}, dstore = victim word cnt.
  - On dwait=0: cnt++. After word WORDS-1 completes: cnt=0, clear dirty, → FILL.
- FILL:
  - dREN=1, daddr = {req tag, idx, cnt, 00}.
  - On dwait=0: write dload into victim word cnt, cnt++.
  - After the last word: set v=1, dirty=0, tag; update LRU; → IDLE.
  - The request then hits in the next cycle; for a write, the store data is merged at that hit.
- Handshake: daddr, dstore, dREN, dWEN are held stable while dwait=1. dREN and dWEN are never both 1.
- FLUSH:
  - Entered from IDLE when halt=1; halt takes priority over dmemREN/dmemWEN in the same cycle.
  - Walks (set, way) from (0,0) upward, way fastest.
  - Clean or invalid entries are skipped in 1 cycle each.
  - Dirty entries are written back as in WB, then the dirty bit is cleared.
  - After (SETS-1, WAYS-1): → DONE.
- halt rising during WB or FILL: the current block transfer completes, then → FLUSH, without returning to IDLE.
- DONE: flushed=1, no memory requests, dhit=0; exit only via reset.
- Counter wrap: cnt is BLK_W bits. With WORDS=1 each transfer is a single word.

Test Plan:
- Read-miss fill: WAYS=2, WORDS=2. Read 0x0000_0040 from reset → dREN at 0x40 then 0x44 (dwait 2 cycles each) → dhit next cycle, dmemload = mem[0x40].
- Write hit then dirty eviction: write 0xDEAD_BEEF to 0x40, then miss 0x140 and 0x240 (same set, idx=0) → WB of 0x40/0x44 with dstore = 0xDEADBEEF first, then FILL of 0x240.
- LRU, WAYS=4: touch tags A, B, C, D in one set, re-read A, miss E → B evicted; A, C, D still hit.
- Flush: dirty blocks in sets 0 and 7 → exactly 2×WORDS dWEN transfers in set order, then flushed=1 held.
- Simultaneous halt and dmemREN miss in IDLE → no FILL; FSM goes to FLUSH.
- Reset asserted mid-FILL after word 0 → outputs zero immediately; the same address then misses again.

Source files
------------

// File: rtl/dcache_lru_wb.sv
// Set-associative write-back, write-allocate data cache with age-counter LRU
// replacement and a halt-driven flush engine that drains every dirty block.
module dcache_lru_wb #(
    parameter int WAYS   = 2,
    parameter int WORDS  = 2,
    parameter int SETS   = 8,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [31:0]       dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload,
    output logic              dhit,
    output logic              flushed,
    output logic              dREN,
    output logic              dWEN,
    output logic [31:0]       daddr,
    output logic [WORD_W-1:0] dstore,
    input  logic [WORD_W-1:0] dload,
    input  logic              dwait
);

    localparam int IDX_W = $clog2(SETS);
    localparam int BLK_W = $clog2(WORDS);
    localparam int TAG_W = 32 - IDX_W - BLK_W - 2;
    localparam int AGE_W = $clog2(WAYS);
    // Field widths kept at least 1 bit so SETS=1 / WORDS=1 stay legal.
    localparam int SI_W  = (IDX_W > 0) ? IDX_W : 1;
    localparam int CNT_W = (BLK_W > 0) ? BLK_W : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [SI_W-1:0]  idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [AGE_W-1:0] way_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        FLUSH,
        DONE
    } state_t;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    idx_t   midx_q;
    tag_t   mtag_q;
    way_t   vway_q;
    idx_t   fset_q;
    way_t   fway_q;

    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    way_t              age_q   [SETS][WAYS];
    tag_t              tag_q   [SETS][WAYS];
    logic [WORD_W-1:0] data_q  [SETS][WAYS][WORDS];

    idx_t req_idx;
    cnt_t req_blk;
    tag_t req_tag;
    logic hit;
    way_t hit_way;
    logic vic_inv;
    way_t vic_way;
    logic cnt_last;
    cnt_t cnt_next;
    logic fl_dirty;
    logic fl_last;

    logic hit_we, fill_we, fill_done, wb_done, fl_adv, fl_clr, miss_start;
    logic lru_en;
    idx_t lru_set;
    way_t lru_way;

    function automatic logic [31:0] blk_addr(input tag_t t, input idx_t i, input cnt_t c);
        logic [31:0] a;
        a = 32'(t) << (IDX_W + BLK_W + 2);
        a = a | ((32'(i) & 32'(SETS - 1)) << (BLK_W + 2));
        a = a | ((32'(c) & 32'(WORDS - 1)) << 2);
        return a;
    endfunction

    assign req_idx  = idx_t'((dmemaddr >> (BLK_W + 2)) & 32'(SETS - 1));
    assign req_blk  = cnt_t'((dmemaddr >> 2) & 32'(WORDS - 1));
    assign req_tag  = tag_t'(dmemaddr >> (IDX_W + BLK_W + 2));
    assign cnt_last = (cnt_q == cnt_t'(WORDS - 1));
    assign cnt_next = (WORDS == 1) ? '0 : cnt_q + cnt_t'(1);
    assign fl_dirty = valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q];
    assign fl_last  = (fset_q == idx_t'(SETS - 1)) && (fway_q == way_t'(WAYS - 1));

    // Tag compare and victim choice for the request currently on the bus.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_inv = 1'b0;
        vic_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_inv && !valid_q[req_idx][w]) begin
                vic_inv = 1'b1;
                vic_way = way_t'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_inv && (age_q[req_idx][w] == way_t'(WAYS - 1))) vic_way = way_t'(w);
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dhit       = 1'b0;
        dmemload   = '0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        flushed    = 1'b0;
        hit_we     = 1'b0;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        wb_done    = 1'b0;
        fl_adv     = 1'b0;
        fl_clr     = 1'b0;
        miss_start = 1'b0;
        lru_en     = 1'b0;
        lru_set    = req_idx;
        lru_way    = hit_way;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                end else if (dmemREN || dmemWEN) begin
                    if (hit) begin
                        dhit   = 1'b1;
                        lru_en = 1'b1;
                        hit_we = dmemWEN;
                        if (dmemREN) dmemload = data_q[req_idx][hit_way][req_blk];
                    end else begin
                        miss_start = 1'b1;
                        cnt_d      = '0;
                        state_d    = (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way])
                                     ? WB : FILL;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tag_q[midx_q][vway_q], midx_q, cnt_q);
                dstore = data_q[midx_q][vway_q][cnt_q];
                if (!dwait) begin
                    cnt_d = cnt_next;
                    if (cnt_last) begin
                        cnt_d   = '0;
                        wb_done = 1'b1;
                        state_d = halt ? FLUSH : FILL;
                    end
                end
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = blk_addr(mtag_q, midx_q, cnt_q);
                if (!dwait) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_next;
                    if (cnt_last) begin
                        cnt_d     = '0;
                        fill_done = 1'b1;
                        lru_en    = 1'b1;
                        lru_set   = midx_q;
                        lru_way   = vway_q;
                        state_d   = halt ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                if (fl_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = blk_addr(tag_q[fset_q][fway_q], fset_q, cnt_q);
                    dstore = data_q[fset_q][fway_q][cnt_q];
                    if (!dwait) begin
                        cnt_d = cnt_next;
                        if (cnt_last) begin
                            cnt_d  = '0;
                            fl_adv = 1'b1;
                            fl_clr = 1'b1;
                        end
                    end
                end else begin
                    fl_adv = 1'b1;
                end
                if (fl_adv && fl_last) state_d = DONE;
            end
            DONE: flushed = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            midx_q  <= '0;
            mtag_q  <= '0;
            vway_q  <= '0;
            fset_q  <= '0;
            fway_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= way_t'(w);
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (miss_start) begin
                midx_q <= req_idx;
                mtag_q <= req_tag;
                vway_q <= vic_way;
            end
            if (hit_we) dirty_q[req_idx][hit_way] <= 1'b1;
            if (wb_done) dirty_q[midx_q][vway_q] <= 1'b0;
            if (fill_done) begin
                valid_q[midx_q][vway_q] <= 1'b1;
                dirty_q[midx_q][vway_q] <= 1'b0;
            end
            if (fl_clr) dirty_q[fset_q][fway_q] <= 1'b0;
            // Accessed way becomes youngest; only ways younger than it age by one.
            if (lru_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (way_t'(w) == lru_way)
                        age_q[lru_set][w] <= '0;
                    else if (age_q[lru_set][w] < age_q[lru_set][lru_way])
                        age_q[lru_set][w] <= age_q[lru_set][w] + way_t'(1);
                end
            end
            if (fl_adv && !fl_last) begin
                if (fway_q == way_t'(WAYS - 1)) begin
                    fway_q <= '0;
                    fset_q <= fset_q + idx_t'(1);
                end else begin
                    fway_q <= fway_q + way_t'(1);
                end
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; valid bits alone decide whether their contents count.
    always_ff @(posedge CLK) begin
        if (hit_we) data_q[req_idx][hit_way][req_blk] <= dmemstore;
        if (fill_we) data_q[midx_q][vway_q][cnt_q] <= dload;
        if (fill_done) tag_q[midx_q][vway_q] <= mtag_q;
    end

endmodule
